// File: rtl/agc_iq_param_if.sv
// Sample/control bundle for the parametrised I/Q AGC.
// Strobes are single-cycle qualifiers with no backpressure: in_valid marks a sample, out_valid marks a result.
interface agc_iq_param_if #(
   parameter int DW = 17,
   parameter int GW = 18
);
   logic                 in_valid;
   logic signed [DW-1:0] in_real;
   logic signed [DW-1:0] in_imag;
   logic        [DW-2:0] target;
   logic                 freeze;
   logic                 gain_load;
   logic signed [GW-1:0] gain_value;
   logic                 out_valid;
   logic signed [DW-1:0] out_real;
   logic signed [DW-1:0] out_imag;
   logic signed [GW-1:0] gain;
   logic                 at_min;
   logic                 at_max;
   logic                 locked;

   modport master (
      output in_valid, in_real, in_imag, target, freeze, gain_load, gain_value,
      input  out_valid, out_real, out_imag, gain, at_min, at_max, locked
   );

   modport slave (
      input  in_valid, in_real, in_imag, target, freeze, gain_load, gain_value,
      output out_valid, out_real, out_imag, gain, at_min, at_max, locked
   );
endinterface

// File: rtl/agc_iq_param.sv
// Parametrised complex AGC: multiply, round/saturate, peak magnitude, attack/decay gain loop.
// Optional lock detector enabled by defining AGC_LOCK_DET_EN.
module agc_iq_param #(
   parameter int DW           = 17,
   parameter int GW           = 18,
   parameter int FRAC         = 15,
   parameter int ATTACK_SHIFT = 3,
   parameter int DECAY_SHIFT  = 6,
   parameter int GAIN_INIT    = 32564,
   parameter int GAIN_MIN     = 0,
   parameter int GAIN_MAX     = (1 << (GW-1)) - 1,
   parameter int LOCK_TOL     = 64,
   parameter int LOCK_CNT     = 16
) (
   input  logic           clk,
   input  logic           rst,
   agc_iq_param_if.slave  bus
);
   localparam int PW  = DW + GW;
   localparam int PW1 = PW + 1;
   localparam int GW2 = GW + 2;
   localparam int EW  = DW + 1;

   localparam logic signed [GW-1:0]  GINIT  = GW'(GAIN_INIT);
   localparam logic signed [GW-1:0]  GMIN   = GW'(GAIN_MIN);
   localparam logic signed [GW-1:0]  GMAX   = GW'(GAIN_MAX);
   localparam logic signed [GW2-1:0] GMIN_X = GW2'(GAIN_MIN);
   localparam logic signed [GW2-1:0] GMAX_X = GW2'(GAIN_MAX);
   localparam logic signed [PW:0]    RND    = PW1'(1) << (FRAC-1);
   localparam logic signed [DW-1:0]  SMAX   = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0]  SMIN   = {1'b1, {(DW-2){1'b0}}, 1'b1};

   logic signed [GW-1:0] gain_r, gain_nxt, upd_gain, load_gain;
   logic                 v1, ov_r, v3;
   logic signed [PW-1:0] prod_re, prod_im;
   logic signed [DW-1:0] out_re, out_im;
   logic        [DW-2:0] mag;
   logic signed [EW-1:0] err, step;

   // Round half up, then saturate symmetrically so the most negative code never appears.
   function automatic logic signed [DW-1:0] scale(input logic signed [PW-1:0] p);
      logic signed [PW:0] s;
      logic signed [PW:0] r;
      s = PW1'(p) + RND;
      r = s >>> FRAC;
      if (r > PW1'(SMAX))      return SMAX;
      else if (r < PW1'(SMIN)) return SMIN;
      else                     return r[DW-1:0];
   endfunction

   function automatic logic [DW-2:0] abs_mag(input logic signed [DW-1:0] x);
      logic signed [DW-1:0] n;
      n = -x;
      return x[DW-1] ? n[DW-2:0] : x[DW-2:0];
   endfunction

   function automatic logic signed [GW-1:0] clamp(input logic signed [GW2-1:0] v);
      if (v < GMIN_X)      return GMIN;
      else if (v > GMAX_X) return GMAX;
      else                 return v[GW-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         prod_re <= '0;
         prod_im <= '0;
         ov_r    <= 1'b0;
         out_re  <= '0;
         out_im  <= '0;
         v3      <= 1'b0;
         mag     <= '0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            prod_re <= PW'(bus.in_real) * PW'(gain_r);
            prod_im <= PW'(bus.in_imag) * PW'(gain_r);
         end
         ov_r <= v1;
         if (v1) begin
            out_re <= scale(prod_re);
            out_im <= scale(prod_im);
         end
         v3 <= ov_r;
         if (ov_r) begin
            mag <= (abs_mag(out_re) > abs_mag(out_im)) ? abs_mag(out_re) : abs_mag(out_im);
         end
      end
   end

   // Overshoot pulls the gain down fast (attack); undershoot lets it creep up (decay).
   always_comb begin
      err       = $signed({2'b00, bus.target}) - $signed({2'b00, mag});
      step      = err[EW-1] ? (err >>> ATTACK_SHIFT) : (err >>> DECAY_SHIFT);
      upd_gain  = clamp(GW2'(gain_r) + GW2'(step));
      load_gain = clamp(GW2'(bus.gain_value));
      gain_nxt  = gain_r;
      if (bus.gain_load)   gain_nxt = load_gain;
      else if (bus.freeze) gain_nxt = gain_r;
      else if (v3)         gain_nxt = upd_gain;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) gain_r <= GINIT;
      else     gain_r <= gain_nxt;
   end

`ifdef AGC_LOCK_DET_EN
   localparam int CW = $clog2(LOCK_CNT + 1);

   logic [CW-1:0] lock_cnt, cnt_nxt;
   logic [EW-1:0] err_abs;
   logic          locked_r;

   always_comb begin
      err_abs = err[EW-1] ? EW'(-err) : EW'(err);
      cnt_nxt = lock_cnt;
      if (bus.gain_load) begin
         cnt_nxt = '0;
      end else if (v3 && !bus.freeze) begin
         if (err_abs <= EW'(LOCK_TOL))
            cnt_nxt = (lock_cnt >= CW'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;
         else
            cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_cnt <= '0;
         locked_r <= 1'b0;
      end else begin
         lock_cnt <= cnt_nxt;
         locked_r <= (cnt_nxt >= CW'(LOCK_CNT));
      end
   end

   assign bus.locked = locked_r;
`else
   localparam bit LOCK_PARAMS_OK = (LOCK_TOL >= 0) && (LOCK_CNT > 0);
   assign bus.locked = 1'b0 && LOCK_PARAMS_OK;
`endif

   assign bus.out_valid = ov_r;
   assign bus.out_real  = out_re;
   assign bus.out_imag  = out_im;
   assign bus.gain      = gain_r;
   assign bus.at_min    = (gain_r == GMIN);
   assign bus.at_max    = (gain_r == GMAX);
endmodule

// File: tb/tb_agc_iq_param.sv
// Bench for agc_iq_param: directed vector table, hand-written loop sequences and random traffic
// checked against an event-queue reference model of the gain loop.
module tb_agc_iq_param;
   localparam int DW = 17;
   localparam int GW = 18;
   localparam longint GAIN_INIT = 32564;
   localparam longint GAIN_MIN  = 0;
   localparam longint GAIN_MAX  = 131071;
   localparam longint SAT       = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;

   agc_iq_param_if #(.DW(DW), .GW(GW)) bus();
   agc_iq_param #(.DW(DW), .GW(GW)) dut (.clk(clk), .rst(rst), .bus(bus));

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0]          due;
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } out_ev_t;
   typedef struct {
      int unsigned due;
      longint      mag;
   } mag_ev_t;

   out_ev_t exp_q[$];
   mag_ev_t mag_q[$];

   int unsigned cyc;
   longint gain_m, ore_m, oim_m;
   bit     ov_m, locked_m;
   int     lock_cnt_m;
   int     n_checks = 0;
   int     n_errors = 0;

   typedef struct {
      longint g;
      longint re;
      longint im;
      longint exp_re;
      longint exp_im;
      longint exp_g;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint clampg(input longint v);
      if (v < GAIN_MIN) return GAIN_MIN;
      if (v > GAIN_MAX) return GAIN_MAX;
      return v;
   endfunction

   function automatic longint scale_m(input longint x, input longint g);
      longint r;
      r = (x * g + 16384) >>> 15;
      if (r > SAT)  return SAT;
      if (r < -SAT) return -SAT;
      return r;
   endfunction

   function automatic longint absl(input longint x);
      return (x < 0) ? -x : x;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      mag_q.delete();
      gain_m     = GAIN_INIT;
      ore_m      = 0;
      oim_m      = 0;
      ov_m       = 1'b0;
      lock_cnt_m = 0;
      locked_m   = 1'b0;
   endtask

   // One clock edge of the reference: gain decision, output due, then accept new sample.
   task automatic model_edge();
      longint g_old, m, err, step, a, b;
      bit has_upd;
      out_ev_t ev;
      mag_ev_t me;
      cyc++;
      if (rst) begin
         model_reset();
         return;
      end
      g_old   = gain_m;
      has_upd = 1'b0;
      m       = 0;
      if (mag_q.size() > 0 && mag_q[0].due == cyc) begin
         has_upd = 1'b1;
         m = mag_q.pop_front().mag;
      end
      if (bus.gain_load) begin
         gain_m     = clampg(longint'(bus.gain_value));
         lock_cnt_m = 0;
      end else if (!bus.freeze && has_upd) begin
         err    = longint'(bus.target) - m;
         step   = (err < 0) ? (err >>> 3) : (err >>> 6);
         gain_m = clampg(gain_m + step);
         if (absl(err) <= 64) lock_cnt_m = (lock_cnt_m < 16) ? lock_cnt_m + 1 : 16;
         else                 lock_cnt_m = 0;
      end
`ifdef AGC_LOCK_DET_EN
      locked_m = (lock_cnt_m >= 16);
`else
      locked_m = 1'b0;
`endif
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         ev    = exp_q.pop_front();
         ov_m  = 1'b1;
         ore_m = longint'(ev.re);
         oim_m = longint'(ev.im);
         a = absl(ore_m);
         b = absl(oim_m);
         me.due = cyc + 2;
         me.mag = (a > b) ? a : b;
         mag_q.push_back(me);
      end else begin
         ov_m = 1'b0;
      end
      if (bus.in_valid) begin
         ev.due = cyc + 1;
         ev.re  = DW'(scale_m(longint'(bus.in_real), g_old));
         ev.im  = DW'(scale_m(longint'(bus.in_imag), g_old));
         exp_q.push_back(ev);
      end
   endtask

   task automatic compare_all();
      check("out_valid", longint'(bus.out_valid), longint'(ov_m));
      check("out_real",  longint'(bus.out_real),  ore_m);
      check("out_imag",  longint'(bus.out_imag),  oim_m);
      check("gain",      longint'(bus.gain),      gain_m);
      check("at_min",    longint'(bus.at_min),    longint'(gain_m == GAIN_MIN));
      check("at_max",    longint'(bus.at_max),    longint'(gain_m == GAIN_MAX));
      check("locked",    longint'(bus.locked),    longint'(locked_m));
   endtask

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive_idle();
      bus.in_valid  = 1'b0;
      bus.in_real   = '0;
      bus.in_imag   = '0;
      bus.gain_load = 1'b0;
   endtask

   task automatic load_gain(input longint g);
      drive_idle();
      bus.freeze     = 1'b1;
      bus.gain_load  = 1'b1;
      bus.gain_value = GW'(g);
      tick();
      bus.gain_load  = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic send(input longint re, input longint im);
      bus.in_valid = 1'b1;
      bus.in_real  = DW'(re);
      bus.in_imag  = DW'(im);
   endtask

   // ---------------- test ----------------
   initial begin
      vecs[0] = '{32768,   1000,  -1000,   1000,  -1000, 32768};
      vecs[1] = '{65536,  40000, -40000,  65535, -65535, 65536};
      vecs[2] = '{32768, -65536,      5, -65535,      5, 32768};
      vecs[3] = '{16384,      3,     -3,      2,     -1, 16384};
      vecs[4] = '{16384,      1,     -1,      1,      0, 16384};
      vecs[5] = '{-5000,    100,    100,      0,      0,     0};
      vecs[6] = '{131071, 65535,      1,  65535,      4, 131071};

      cyc = 0;
      model_reset();
      drive_idle();
      bus.target     = '0;
      bus.freeze     = 1'b0;
      bus.gain_value = '0;

      // reset state
      tick();
      tick();
      check("reset_gain", longint'(bus.gain), GAIN_INIT);
      check("reset_out_valid", longint'(bus.out_valid), 0);
      rst = 1'b0;
      tick();

      // directed vectors with the loop frozen
      foreach (vecs[i]) begin
         load_gain(vecs[i].g);
         send(vecs[i].re, vecs[i].im);
         tick();
         drive_idle();
         tick();
         check("vec_out_valid", longint'(bus.out_valid), 1);
         check("vec_out_real",  longint'(bus.out_real), vecs[i].exp_re);
         check("vec_out_imag",  longint'(bus.out_imag), vecs[i].exp_im);
         check("vec_gain",      longint'(bus.gain),     vecs[i].exp_g);
         tick();
         tick();
      end
      check("vec_at_max", longint'(bus.at_max), 1);

      // attack: one large sample
      load_gain(32768);
      bus.freeze = 1'b0;
      bus.target = 16'd6553;
      send(20000, 0);
      tick();
      drive_idle();
      tick();
      tick();
      check("attack_gain_before", longint'(bus.gain), 32768);
      tick();
      check("attack_gain_after", longint'(bus.gain), 31087);
      tick();

      // decay into the upper clamp
      load_gain(131000);
      bus.freeze = 1'b0;
      for (int i = 0; i < 10; i++) begin
         send(0, 0);
         tick();
         if (i == 2) check("decay_gain_pre", longint'(bus.gain), 131000);
         if (i == 3 || i == 9) begin
            check("decay_gain_clamp", longint'(bus.gain), 131071);
            check("decay_at_max", longint'(bus.at_max), 1);
         end
      end
      drive_idle();

`ifdef AGC_LOCK_DET_EN
      load_gain(32768);
      bus.freeze = 1'b0;
      bus.target = 16'd6553;
      for (int i = 0; i < 25; i++) begin
         send((i < 19) ? 6553 : 20000, 0);
         tick();
         if (i == 17) check("lock_not_yet", longint'(bus.locked), 0);
         if (i == 18) check("lock_set", longint'(bus.locked), 1);
         if (i == 21) check("lock_held", longint'(bus.locked), 1);
         if (i == 22) check("lock_drop", longint'(bus.locked), 0);
      end
      drive_idle();
`else
      check("locked_tied_low", longint'(bus.locked), 0);
`endif

      // random traffic with a mid-stream reset
      bus.freeze = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.in_real    = DW'(longint'($urandom_range(0, 131071)) - 65536);
         bus.in_imag    = DW'(longint'($urandom_range(0, 131071)) - 65536);
         bus.target     = 16'($urandom_range(0, 65535));
         bus.freeze     = ($urandom_range(0, 15) == 0);
         bus.gain_load  = ($urandom_range(0, 31) == 0);
         bus.gain_value = GW'(longint'($urandom_range(0, 262143)) - 131072);
         tick();
         if (i == 700) begin
            #3;
            rst = 1'b1;
            #1;
            check("rst_async_gain", longint'(bus.gain), GAIN_INIT);
            check("rst_async_out_valid", longint'(bus.out_valid), 0);
            check("rst_async_out_real", longint'(bus.out_real), 0);
            model_reset();
            drive_idle();
            bus.freeze = 1'b0;
            tick();
            tick();
            rst = 1'b0;
            send(1234, -4321);
            tick();
            check("rst_first_valid_early", longint'(bus.out_valid), 0);
            drive_idle();
            tick();
            check("rst_first_valid", longint'(bus.out_valid), 1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
